mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Memory-interface block directly downstream of the IF and MEM stages, and the only driver of the 8-bit external memory bus.
- Accepts word-fetch requests from IF and load/store requests of 1/2/4 bytes from MEM.
- Serialises each request into byte accesses and returns assembled little-endian data with a one-cycle done pulse.
- MEM has priority over IF. Supports IF-fetch abort on branch redirect and a global pause on rdy.

Parameters:
ADDR_W, 32, width of all address ports
FETCH_BYTES, 4, bytes per instruction fetch (fixed 4 for RV32I)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
rdy  in  1  pause when low
if_req_i  in  1  IF fetch request, held until if_done_o
if_addr_i  in  ADDR_W  fetch address
if_flush_i  in  1  abort pending/in-flight fetch (branch taken)
if_done_o  out  1  one-cycle pulse, if_inst_o valid
if_inst_o  out  32  fetched instruction
mem_req_i  in  1  MEM request, held until mem_done_o
mem_we_i  in  1  1=store, 0=load
mem_len_i  in  2  00=1B, 01=2B, 10=4B, 11 treated as 4B
mem_addr_i  in  ADDR_W  byte address
mem_wdata_i  in  32  store data; low bytes used
mem_done_o  out  1  one-cycle pulse
mem_rdata_o  out  32  load data, zero-extended; MEM stage does sign extension
mem_din  in  8  memory read bus
mem_dout  out  8  memory write bus
mem_a  out  ADDR_W  memory address
mem_wr  out  1  1=write

Behaviour:
- Reset (rst=0, async): state IDLE; all counters 0; mem_a=0; mem_dout=0; mem_wr=0; if_done_o=0; mem_done_o=0; if_inst_o=0; mem_rdata_o=0. Reset mid-transfer drops the transfer without a done pulse.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, COOL.
- IDLE: at an edge with rdy=1:
  - If mem_req_i: latch addr/len/we/wdata; go to MEM_RD or MEM_WR.
  - Else if if_req_i and !if_flush_i: latch addr, len=4; go to IF_RD.
  - mem_a=addr of byte 0 in the cycle after the accept edge (registered output).
- Reads: byte k address driven in cycle k after the accept edge (cycle 0 = cycle after accept). mem_din carries that byte in cycle k+1 and is sampled at the end of cycle k+1. Issue counter and capture counter are kept separately.
  - n-byte read: done pulse and data registered in cycle n+1 after the accept edge; 4-byte read → cycle 5.
  - Byte k lands in data[8k+7:8k]; unused upper bytes are 0.
- Writes: cycle k drives mem_a=addr+k, mem_dout=byte k of wdata, mem_wr=1. mem_done_o pulses in cycle n; mem_wr=0 in that cycle.
- After any done pulse: state COOL for exactly that cycle. No request is sampled at the COOL→IDLE edge, so a requester dropping req on seeing done is never re-accepted. Next accept is possible one edge later.
- Address arithmetic: addr+k wraps modulo 2^ADDR_W. No alignment requirement; misaligned words are legal.
- if_flush_i:
  - In IF_RD: go to COOL at the next edge with no if_done_o; in-flight read data is discarded.
  - In IDLE: suppresses IF acceptance that edge.
  - Ignored in MEM_RD/MEM_WR.
- Simultaneous if_req_i and mem_req_i in IDLE: MEM wins; IF stays pending.
- rdy=0:
  - All registers hold; mem_wr gated to 0 combinationally.
  - At the first rdy=1 edge after a pause, read states discard that edge's sample, set issue counter = capture counter, and re-drive mem_a=addr+capture. Done is delayed by the replay, never corrupted.
  - Writes resume at the held byte, which is rewritten once.
- done outputs are never high for two consecutive cycles.

Decomposition:
- Shared defines package:
  - state encodings.
  - mem_len codes.
  - FETCH_BYTES.
  - ADDR_W/RegBus widths, reusing existing InstAddrBus/RegBus/DataBus defines.
- One natural sub-module: byte_assembler, an 8→32 shift/collect register with capture index, clear and zero-fill.

Test Plan:
- IF fetch at 0x0000_0010, memory bytes 13 05 00 00 → mem_a=0x10..0x13 in cycles 0..3; if_done_o in cycle 5 with if_inst_o=0x0000_0513; mem_wr=0 throughout.
- MEM store word 0xDEADBEEF to 0x100 → mem_a/mem_dout/mem_wr = 0x100/EF/1, 0x101/BE/1, 0x102/AD/1, 0x103/DE/1; mem_done_o in cycle 4.
- if_req_i and mem_req_i together (load byte 0x200 = 0x80) → MEM served first; mem_rdata_o=0x0000_0080 in cycle 2; COOL; IF accepted at the following edge.
- IF fetch, if_flush_i asserted in cycle 2 → no if_done_o; IDLE by cycle 4; a new fetch to 0x40 completes with correct data.
- rdy=0 for 3 cycles during cycle 2 of a word load → issue rewinds, bytes match memory, done delayed exactly by pause+replay; mem_wr never 1.
- rst=0 asserted mid-store (after byte 1) → all outputs 0 asynchronously, no done pulse; after release, a new load of 0x100 reads back EF BE plus the original bytes 2–3.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arbiter_pkg : bus widths, state and length encodings for mem_arbiter
// Revision 1.0
// ============================================================================
package mem_arbiter_pkg;

    localparam int INST_ADDR_BUS_W  = 32;
    localparam int REG_BUS_W        = 32;
    localparam int DATA_BUS_W       = 8;
    localparam int FETCH_BYTES_RV32 = 4;

    localparam logic [1:0] LEN_1B = 2'b00;
    localparam logic [1:0] LEN_2B = 2'b01;
    localparam logic [1:0] LEN_4B = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_COOL   = 3'd4
    } state_e;

    // Code 2'b11 is not a legal size and is served as a full word.
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            LEN_1B:  return 3'd1;
            LEN_2B:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_byte_assembler.sv
`default_nettype none
// ============================================================================
// mem_arbiter_byte_assembler : collects bus bytes into a little-endian word
// Revision 1.0
// ============================================================================
module mem_arbiter_byte_assembler
    import mem_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  cap_i,
    input  logic [1:0]            idx_i,
    input  logic [DATA_BUS_W-1:0] byte_i,
    output logic [REG_BUS_W-1:0]  word_o
);

    logic [REG_BUS_W-1:0] data_q;
    logic [REG_BUS_W-1:0] data_d;

    // word_o already includes the byte captured this cycle so the final
    // byte and the result register can be loaded on the same edge.
    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (cap_i) begin
            data_d[{idx_i, 3'b000} +: 8] = byte_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign word_o = data_d;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : serialises IF fetches and MEM loads/stores onto an 8-bit bus
// Revision 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = INST_ADDR_BUS_W,
    parameter int FETCH_BYTES = FETCH_BYTES_RV32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    input  logic                  if_flush_i,
    output logic                  if_done_o,
    output logic [REG_BUS_W-1:0]  if_inst_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_len_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [REG_BUS_W-1:0]  mem_wdata_i,
    output logic                  mem_done_o,
    output logic [REG_BUS_W-1:0]  mem_rdata_o,
    input  logic [DATA_BUS_W-1:0] mem_din,
    output logic [DATA_BUS_W-1:0] mem_dout,
    output logic [ADDR_W-1:0]     mem_a,
    output logic                  mem_wr
);

    state_e                state_q,     state_d;
    logic [ADDR_W-1:0]     addr_q,      addr_d;
    logic [REG_BUS_W-1:0]  wdata_q,     wdata_d;
    logic [2:0]            nbytes_q,    nbytes_d;
    logic [2:0]            iss_q,       iss_d;
    logic [2:0]            cap_q,       cap_d;
    logic                  drv_q,       drv_d;
    logic                  prv_q,       prv_d;
    logic [ADDR_W-1:0]     mem_a_q,     mem_a_d;
    logic [DATA_BUS_W-1:0] dout_q,      dout_d;
    logic                  wr_q,        wr_d;
    logic                  if_done_q,   if_done_d;
    logic                  mem_done_q,  mem_done_d;
    logic [REG_BUS_W-1:0]  if_inst_q,   if_inst_d;
    logic [REG_BUS_W-1:0]  mem_rdata_q, mem_rdata_d;
    logic                  stall_q;
    logic [2:0]            next_iss;

    logic                  accept_mem;
    logic                  accept_if;
    logic                  in_rd;
    logic                  if_abort;
    logic                  asm_cap;
    logic [REG_BUS_W-1:0]  asm_word;

    assign accept_mem = (state_q == ST_IDLE) && rdy && mem_req_i;
    assign accept_if  = (state_q == ST_IDLE) && rdy && !mem_req_i && if_req_i && !if_flush_i;
    assign in_rd      = (state_q == ST_IF_RD) || (state_q == ST_MEM_RD);
    assign if_abort   = (state_q == ST_IF_RD) && if_flush_i;
    // prv_q marks that mem_din carries the byte addressed in the previous cycle.
    assign asm_cap    = in_rd && !if_abort && rdy && !stall_q && prv_q;

    mem_arbiter_byte_assembler u_asm (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (accept_mem || accept_if),
        .cap_i  (asm_cap),
        .idx_i  (cap_q[1:0]),
        .byte_i (mem_din),
        .word_o (asm_word)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        nbytes_d    = nbytes_q;
        iss_d       = iss_q;
        cap_d       = cap_q;
        drv_d       = drv_q;
        prv_d       = prv_q;
        mem_a_d     = mem_a_q;
        dout_d      = dout_q;
        wr_d        = wr_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        next_iss    = iss_q + 3'd1;

        case (state_q)
            ST_IDLE: begin
                if (accept_mem) begin
                    addr_d   = mem_addr_i;
                    wdata_d  = mem_wdata_i;
                    nbytes_d = len_to_bytes(mem_len_i);
                    mem_a_d  = mem_addr_i;
                    iss_d    = 3'd0;
                    cap_d    = 3'd0;
                    drv_d    = 1'b1;
                    prv_d    = 1'b0;
                    if (mem_we_i) begin
                        state_d = ST_MEM_WR;
                        dout_d  = mem_wdata_i[7:0];
                        wr_d    = 1'b1;
                    end else begin
                        state_d = ST_MEM_RD;
                    end
                end else if (accept_if) begin
                    state_d  = ST_IF_RD;
                    addr_d   = if_addr_i;
                    nbytes_d = 3'(FETCH_BYTES);
                    mem_a_d  = if_addr_i;
                    iss_d    = 3'd0;
                    cap_d    = 3'd0;
                    drv_d    = 1'b1;
                    prv_d    = 1'b0;
                end
            end

            ST_IF_RD, ST_MEM_RD: begin
                if (if_abort) begin
                    state_d = ST_COOL;
                    drv_d   = 1'b0;
                    prv_d   = 1'b0;
                end else if (rdy) begin
                    if (stall_q) begin
                        // Bus contents during the pause are untrusted: replay
                        // from the first byte not yet captured.
                        iss_d   = cap_q;
                        mem_a_d = addr_q + ADDR_W'(cap_q);
                        drv_d   = 1'b1;
                        prv_d   = 1'b0;
                    end else begin
                        prv_d = drv_q;
                        if (drv_q) begin
                            if (next_iss < nbytes_q) begin
                                iss_d   = next_iss;
                                mem_a_d = addr_q + ADDR_W'(next_iss);
                            end else begin
                                drv_d = 1'b0;
                            end
                        end
                        if (prv_q) begin
                            cap_d = cap_q + 3'd1;
                            if (cap_q + 3'd1 == nbytes_q) begin
                                state_d = ST_COOL;
                                drv_d   = 1'b0;
                                prv_d   = 1'b0;
                                if (state_q == ST_IF_RD) begin
                                    if_done_d = 1'b1;
                                    if_inst_d = asm_word;
                                end else begin
                                    mem_done_d  = 1'b1;
                                    mem_rdata_d = asm_word;
                                end
                            end
                        end
                    end
                end
            end

            ST_MEM_WR: begin
                if (rdy) begin
                    if (next_iss < nbytes_q) begin
                        iss_d   = next_iss;
                        mem_a_d = addr_q + ADDR_W'(next_iss);
                        dout_d  = wdata_q[{next_iss[1:0], 3'b000} +: 8];
                    end else begin
                        state_d    = ST_COOL;
                        wr_d       = 1'b0;
                        drv_d      = 1'b0;
                        mem_done_d = 1'b1;
                    end
                end
            end

            ST_COOL: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            nbytes_q    <= '0;
            iss_q       <= '0;
            cap_q       <= '0;
            drv_q       <= 1'b0;
            prv_q       <= 1'b0;
            mem_a_q     <= '0;
            dout_q      <= '0;
            wr_q        <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            nbytes_q    <= nbytes_d;
            iss_q       <= iss_d;
            cap_q       <= cap_d;
            drv_q       <= drv_d;
            prv_q       <= prv_d;
            mem_a_q     <= mem_a_d;
            dout_q      <= dout_d;
            wr_q        <= wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
            stall_q     <= !rdy;
        end
    end

    assign if_done_o   = if_done_q;
    assign if_inst_o   = if_inst_q;
    assign mem_done_o  = mem_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_a       = mem_a_q;
    assign mem_dout    = dout_q;
    assign mem_wr      = wr_q && rdy;

endmodule
`default_nettype wire
